// File: rtl/bg_pkg.sv
// Shared constants, FSM state type and row-base helper for the background
// frame-buffer write path.
package bg_pkg;
    localparam int         FB_WIDTH          = 320;
    localparam int         FB_HEIGHT         = 240;
    localparam int         ADDR_W            = 19;
    localparam logic [7:0] TRANSPARENT_INDEX = 8'h00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } bg_wr_state_t;

    // y*320 built as (y<<8) + (y<<6) so no general multiplier is inferred.
    function automatic logic [ADDR_W-1:0] fb_row_base(input logic [7:0] y);
        logic [ADDR_W-1:0] y_ext;
        y_ext = {{(ADDR_W-8){1'b0}}, y};
        return (y_ext << 8) + (y_ext << 6);
    endfunction
endpackage

// File: rtl/bg_rect_addr_gen.sv
// Column/row/row-base counters for a rectangle walk, with clip flag and
// last-pixel detection for the pixel currently offered.
module bg_rect_addr_gen
    import bg_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              load,
    input  logic              advance,
    input  logic [8:0]        rect_x,
    input  logic [7:0]        rect_y,
    input  logic [8:0]        rect_w,
    input  logic [7:0]        rect_h,
    output logic              in_bounds,
    output logic              last_pix,
    output logic [ADDR_W-1:0] pix_addr
);
    logic [8:0]        rect_x_q, rect_x_d;
    logic [7:0]        rect_y_q, rect_y_d;
    logic [8:0]        rect_w_q, rect_w_d;
    logic [7:0]        rect_h_q, rect_h_d;
    logic [8:0]        col_q, col_d;
    logic [7:0]        row_q, row_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [9:0]        px;
    logic [8:0]        py;
    logic              col_last, row_last;

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        px         = {1'b0, rect_x_q} + {1'b0, col_q};
        py         = {1'b0, rect_y_q} + {1'b0, row_q};
        col_last   = (col_q == rect_w_q - 9'd1);
        row_last   = (row_q == rect_h_q - 8'd1);
        rect_x_d   = rect_x_q;
        rect_y_d   = rect_y_q;
        rect_w_d   = rect_w_q;
        rect_h_d   = rect_h_q;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        if (load) begin
            rect_x_d   = rect_x;
            rect_y_d   = rect_y;
            rect_w_d   = rect_w;
            rect_h_d   = rect_h;
            col_d      = '0;
            row_d      = '0;
            row_base_d = fb_row_base(rect_y);
        end else if (advance) begin
            if (col_last) begin
                col_d      = '0;
                row_d      = row_q + 8'd1;
                row_base_d = row_base_q + ADDR_W'(FB_WIDTH);
            end else begin
                col_d = col_q + 9'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rect_x_q   <= '0;
            rect_y_q   <= '0;
            rect_w_q   <= '0;
            rect_h_q   <= '0;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
        end else begin
            rect_x_q   <= rect_x_d;
            rect_y_q   <= rect_y_d;
            rect_w_q   <= rect_w_d;
            rect_h_q   <= rect_h_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
        end
    end

    assign in_bounds = (px < 10'(FB_WIDTH)) && (py < 9'(FB_HEIGHT));
    assign last_pix  = col_last && row_last;
    assign pix_addr  = row_base_q + ADDR_W'(px);
endmodule

// File: rtl/bg_rect_writer.sv
// Streams palette indices into a rectangle of the 320x240 background RAM.
// Define BG_TRANSPARENT_EN to skip writes of TRANSPARENT_INDEX pixels.
module bg_rect_writer
    import bg_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [8:0]        rect_x,
    input  logic [7:0]        rect_y,
    input  logic [8:0]        rect_w,
    input  logic [7:0]        rect_h,
    input  logic [7:0]        pix_data,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_address,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              done
);
    bg_wr_state_t      state_q, state_d;
    logic              load, accept, in_bounds, last_pix, write_ok;
    logic [ADDR_W-1:0] pix_addr;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_address_q, wr_address_d;
    logic [7:0]        wr_data_q, wr_data_d;

    assign load   = (state_q == IDLE) && start;
    assign accept = pix_valid && pix_ready;

    bg_rect_addr_gen u_addr_gen (
        .Clk       (Clk),
        .Reset     (Reset),
        .load      (load),
        .advance   (accept),
        .rect_x    (rect_x),
        .rect_y    (rect_y),
        .rect_w    (rect_w),
        .rect_h    (rect_h),
        .in_bounds (in_bounds),
        .last_pix  (last_pix),
        .pix_addr  (pix_addr)
    );

    always_ff @(posedge Clk) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (rect_w == '0 || rect_h == '0) ? FINISH : RUN;
            RUN:     if (accept && last_pix) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pix_ready = (state_q == RUN);
        busy      = (state_q != IDLE);
        done      = (state_q == FINISH);
    end

`ifdef BG_TRANSPARENT_EN
    assign write_ok = in_bounds && (pix_data != TRANSPARENT_INDEX);
`else
    assign write_ok = in_bounds;
`endif

    // Address and data only move on a real write so the RAM bus stays quiet.
    always_comb begin
        wr_en_d      = accept && write_ok;
        wr_address_d = wr_address_q;
        wr_data_d    = wr_data_q;
        if (wr_en_d) begin
            wr_address_d = pix_addr;
            wr_data_d    = pix_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_en_q      <= 1'b0;
            wr_address_q <= '0;
            wr_data_q    <= '0;
        end else begin
            wr_en_q      <= wr_en_d;
            wr_address_q <= wr_address_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_address = wr_address_q;
    assign wr_data    = wr_data_q;
endmodule

// File: tb/tb_bg_rect_writer.sv
// Directed self-checking bench for bg_rect_writer: full screen, small and
// clipped rectangles, stalls, empty rectangles, reset abort and transparency.
`timescale 1ns/1ps
module tb_bg_rect_writer;
    logic        Clk = 1'b0;
    logic        Reset, start, pix_valid;
    logic [8:0]  rect_x, rect_w;
    logic [7:0]  rect_y, rect_h, pix_data;
    logic        pix_ready, wr_en, busy, done;
    logic [18:0] wr_address;
    logic [7:0]  wr_data;

    int errors = 0;
    int checks = 0;
    localparam int MAX_CYC = 80000;

    logic [7:0] stim[$];
    int         obs_addr[$];
    logic [7:0] obs_data[$];
    int         obs_cyc[$];
    int         hs_cyc[$];
    int         done_count, done_cycle, end_cycle;

    bg_rect_writer dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .start      (start),
        .rect_x     (rect_x),
        .rect_y     (rect_y),
        .rect_w     (rect_w),
        .rect_h     (rect_h),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .wr_en      (wr_en),
        .wr_address (wr_address),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Drives one rectangle and records writes, handshakes and done timing;
    // cycle 1 is the first cycle after the start edge.
    task automatic run_rect(input logic [8:0] x, input logic [7:0] y,
                            input logic [8:0] w, input logic [7:0] h,
                            input bit toggle, input int restart_cyc);
        int cyc;
        int k;
        bit finished;
        obs_addr.delete();
        obs_data.delete();
        obs_cyc.delete();
        hs_cyc.delete();
        done_count = 0;
        done_cycle = -1;
        end_cycle  = -1;
        k = 0;
        finished = 0;
        rect_x = x; rect_y = y; rect_w = w; rect_h = h;
        start = 1'b1; pix_valid = 1'b0; pix_data = 8'h00;
        step();
        start = 1'b0;
        cyc = 1;
        while (!finished && cyc < MAX_CYC) begin
            if (wr_en) begin
                obs_addr.push_back(int'(wr_address));
                obs_data.push_back(wr_data);
                obs_cyc.push_back(cyc);
            end
            if (done) begin
                done_count++;
                done_cycle = cyc;
            end
            if (!busy) begin
                finished = 1;
                end_cycle = cyc;
            end else begin
                start = 1'b0;
                if (cyc == restart_cyc || (restart_cyc > 0 && done)) begin
                    start = 1'b1;
                    rect_x = 9'd50; rect_y = 8'd50; rect_w = 9'd1; rect_h = 8'd1;
                end
                pix_valid = toggle ? (cyc % 2 == 1) : 1'b1;
                pix_data  = (k < stim.size()) ? stim[k] : 8'h00;
                if (pix_valid && pix_ready) begin
                    hs_cyc.push_back(cyc);
                    k++;
                end
                step();
                cyc++;
            end
        end
        start = 1'b0;
        pix_valid = 1'b0;
        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL timeout: rectangle still busy after %0d cycles", cyc);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; start = 1'b0; pix_valid = 1'b1; pix_data = 8'hFF;
        rect_x = '0; rect_y = '0; rect_w = 9'd4; rect_h = 8'd4;
        repeat (3) step();
        checks++; if (wr_en !== 1'b0)       begin errors++; $display("FAIL rst_wr_en: got %b want 0", wr_en); end
        checks++; if (wr_address !== 19'd0) begin errors++; $display("FAIL rst_wr_address: got %0d want 0", wr_address); end
        checks++; if (wr_data !== 8'd0)     begin errors++; $display("FAIL rst_wr_data: got %0d want 0", wr_data); end
        checks++; if (pix_ready !== 1'b0)   begin errors++; $display("FAIL rst_pix_ready: got %b want 0", pix_ready); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0)        begin errors++; $display("FAIL rst_done: got %b want 0", done); end
        Reset = 1'b0; pix_valid = 1'b0;
        step();
    endtask

    task automatic test_full_screen();
        int bad = 0;
        int first_bad = -1;
        stim.delete();
        for (int i = 0; i < 76800; i++) stim.push_back(8'(i));
        run_rect(9'd0, 8'd0, 9'd320, 8'd240, 1'b0, -1);
        checks++; if (obs_addr.size() != 76800) begin errors++; $display("FAIL fs_count: got %0d want 76800", obs_addr.size()); end
        for (int i = 0; i < obs_addr.size() && i < hs_cyc.size(); i++) begin
            if (obs_addr[i] != i || obs_data[i] !== 8'(i) || obs_cyc[i] != hs_cyc[i] + 1) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL fs_sequence: %0d bad writes, first at index %0d got addr %0d want %0d",
                     bad, first_bad, obs_addr[first_bad], first_bad);
        end
        checks++; if (done_count != 1)     begin errors++; $display("FAIL fs_done_count: got %0d want 1", done_count); end
        checks++; if (done_cycle != 76801) begin errors++; $display("FAIL fs_done_cycle: got %0d want 76801", done_cycle); end
        checks++; if (end_cycle != 76802)  begin errors++; $display("FAIL fs_busy_low: got %0d want 76802", end_cycle); end
    endtask

    task automatic test_small_rect();
        int exp_a[6] = '{1610, 1611, 1612, 1930, 1931, 1932};
        stim = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        run_rect(9'd10, 8'd5, 9'd3, 8'd2, 1'b0, -1);
        checks++; if (obs_addr.size() != 6) begin errors++; $display("FAIL small_count: got %0d want 6", obs_addr.size()); end
        for (int i = 0; i < 6 && i < obs_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] != exp_a[i] || obs_data[i] !== stim[i]) begin
                errors++;
                $display("FAIL small_write[%0d]: got %0d/%h want %0d/%h", i, obs_addr[i], obs_data[i], exp_a[i], stim[i]);
            end
        end
        checks++; if (done_cycle != 7 || done_count != 1) begin errors++; $display("FAIL small_done: got cycle %0d count %0d want 7/1", done_cycle, done_count); end
        checks++; if (end_cycle != 8) begin errors++; $display("FAIL small_busy_low: got %0d want 8", end_cycle); end
    endtask

    task automatic test_clipping();
        stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_rect(9'd318, 8'd239, 9'd4, 8'd2, 1'b0, -1);
        checks++; if (hs_cyc.size() != 8)   begin errors++; $display("FAIL clip_accepted: got %0d want 8", hs_cyc.size()); end
        checks++; if (obs_addr.size() != 2) begin errors++; $display("FAIL clip_count: got %0d want 2", obs_addr.size()); end
        if (obs_addr.size() >= 2) begin
            checks++;
            if (obs_addr[0] != 76798 || obs_data[0] !== 8'h11 || obs_addr[1] != 76799 || obs_data[1] !== 8'h22) begin
                errors++;
                $display("FAIL clip_writes: got %0d/%h %0d/%h want 76798/11 76799/22",
                         obs_addr[0], obs_data[0], obs_addr[1], obs_data[1]);
            end
        end
        checks++; if (done_cycle != 9 || end_cycle != 10) begin errors++; $display("FAIL clip_done: got %0d/%0d want 9/10", done_cycle, end_cycle); end
    endtask

    task automatic test_stall();
        int exp_c[4] = '{2, 4, 6, 8};
        stim = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_rect(9'd100, 8'd2, 9'd4, 8'd1, 1'b1, -1);
        checks++; if (obs_addr.size() != 4) begin errors++; $display("FAIL stall_count: got %0d want 4", obs_addr.size()); end
        for (int i = 0; i < 4 && i < obs_addr.size() && i < hs_cyc.size(); i++) begin
            checks++;
            if (obs_addr[i] != 740 + i || obs_cyc[i] != exp_c[i] || obs_cyc[i] != hs_cyc[i] + 1) begin
                errors++;
                $display("FAIL stall_write[%0d]: got addr %0d cycle %0d want %0d cycle %0d",
                         i, obs_addr[i], obs_cyc[i], 740 + i, exp_c[i]);
            end
        end
        checks++; if (done_cycle != 8) begin errors++; $display("FAIL stall_done: got %0d want 8", done_cycle); end
    endtask

    task automatic test_zero_size();
        stim = '{8'hEE};
        run_rect(9'd5, 8'd5, 9'd0, 8'd3, 1'b0, -1);
        checks++; if (obs_addr.size() != 0 || hs_cyc.size() != 0) begin errors++; $display("FAIL zero_w_writes: got %0d writes %0d accepts want 0", obs_addr.size(), hs_cyc.size()); end
        checks++; if (done_cycle != 1 || end_cycle != 2) begin errors++; $display("FAIL zero_w_done: got %0d/%0d want 1/2", done_cycle, end_cycle); end
        run_rect(9'd5, 8'd5, 9'd3, 8'd0, 1'b0, -1);
        checks++; if (obs_addr.size() != 0 || done_cycle != 1) begin errors++; $display("FAIL zero_h: got %0d writes done %0d want 0/1", obs_addr.size(), done_cycle); end
    endtask

    task automatic test_reset_mid();
        int stray = 0;
        rect_x = 9'd0; rect_y = 8'd0; rect_w = 9'd8; rect_h = 8'd8;
        start = 1'b1; pix_valid = 1'b0; pix_data = 8'h55;
        step();
        start = 1'b0; pix_valid = 1'b1;
        repeat (5) step();
        checks++; if (wr_en !== 1'b1 || wr_address !== 19'd4 || wr_data !== 8'h55) begin errors++; $display("FAIL mid_fifth_write: got %b/%0d/%h want 1/4/55", wr_en, wr_address, wr_data); end
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        checks++;
        if ({wr_en, wr_address, wr_data, pix_ready, busy, done} !== 31'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got en=%b addr=%0d data=%h rdy=%b busy=%b done=%b want all 0",
                     wr_en, wr_address, wr_data, pix_ready, busy, done);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            if (wr_en || busy || done) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL mid_after_reset: got %0d active cycles want 0", stray); end
        pix_valid = 1'b0;
        step();
    endtask

    task automatic test_ignored_start();
        int exp_a[4] = '{320, 321, 640, 641};
        stim = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
        run_rect(9'd0, 8'd1, 9'd2, 8'd2, 1'b0, 2);
        checks++; if (obs_addr.size() != 4) begin errors++; $display("FAIL ign_count: got %0d want 4", obs_addr.size()); end
        for (int i = 0; i < 4 && i < obs_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] != exp_a[i]) begin errors++; $display("FAIL ign_write[%0d]: got %0d want %0d", i, obs_addr[i], exp_a[i]); end
        end
        checks++; if (done_count != 1 || done_cycle != 5 || end_cycle != 6) begin errors++; $display("FAIL ign_done: got count %0d cycle %0d end %0d want 1/5/6", done_count, done_cycle, end_cycle); end
    endtask

    task automatic test_transparency();
`ifdef BG_TRANSPARENT_EN
        int         exp_a[$] = '{1, 3};
        logic [7:0] exp_d[$] = '{8'h07, 8'h09};
`else
        int         exp_a[$] = '{0, 1, 2, 3};
        logic [7:0] exp_d[$] = '{8'h00, 8'h07, 8'h00, 8'h09};
`endif
        stim = '{8'h00, 8'h07, 8'h00, 8'h09};
        run_rect(9'd0, 8'd0, 9'd4, 8'd1, 1'b0, -1);
        checks++; if (obs_addr.size() != exp_a.size()) begin errors++; $display("FAIL transp_count: got %0d want %0d", obs_addr.size(), exp_a.size()); end
        for (int i = 0; i < exp_a.size() && i < obs_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] != exp_a[i] || obs_data[i] !== exp_d[i]) begin
                errors++;
                $display("FAIL transp_write[%0d]: got %0d/%h want %0d/%h", i, obs_addr[i], obs_data[i], exp_a[i], exp_d[i]);
            end
        end
        checks++; if (done_cycle != 5) begin errors++; $display("FAIL transp_done: got %0d want 5", done_cycle); end
    endtask

    initial begin
        test_reset();
        test_small_rect();
        test_clipping();
        test_stall();
        test_zero_size();
        test_reset_mid();
        test_ignored_start();
        test_transparency();
        test_full_screen();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
